// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and per-stage control outputs shared between the pipeline
// datapath (master) and the stall/flush sequencer (slave).
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic [4:0]       id_ex_rd;
    logic             id_ex_memread;
    logic             branch_taken_ex;
    logic             ex_mdu_start;
    logic             mdu_done;
    logic             dmem_req;
    logic             dmem_ready;
    logic             fault_clr;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             mem_wb_bubble;
    logic             fault;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_id, rs2_id, id_ex_rd, id_ex_memread, branch_taken_ex,
               ex_mdu_start, mdu_done, dmem_req, dmem_ready, fault_clr,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
               fault, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, id_ex_rd, id_ex_memread, branch_taken_ex,
               ex_mdu_start, mdu_done, dmem_req, dmem_ready, fault_clr,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
               fault, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer: memory wait, MDU hold, branch flush and
// load-use, with memory-timeout fault and saturating stall/flush counters.
module pipeline_stall_controller #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    pipeline_stall_controller_if.slave  bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MDU_WAIT = 2'b01;
    localparam logic [1:0] ST_FAULT    = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_stall_s, mdu_hold_s, load_use_s, in_fault_s, timeout_s, flush_win_s;
    logic pc_write_s, if_id_write_s, id_ex_write_s, ex_mem_write_s, mem_wb_write_s;
    logic if_id_flush_s, id_ex_bubble_s, ex_mem_bubble_s, mem_wb_bubble_s, fault_s;

    assign in_fault_s  = (state_q == ST_FAULT);
    assign mem_stall_s = bus.dmem_req & ~bus.dmem_ready;
    assign mdu_hold_s  = bus.ex_mdu_start & ~bus.mdu_done & ~in_fault_s;
    assign load_use_s  = bus.id_ex_memread & (bus.id_ex_rd != 5'd0) &
                         ((bus.id_ex_rd == bus.rs1_id) | (bus.id_ex_rd == bus.rs2_id));
    assign timeout_s   = ~in_fault_s & mem_stall_s & (wait_cnt_q == WAIT_LAST);

    // Priority resolution of the hazard sources into stage controls.
    always_comb begin
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        id_ex_write_s   = 1'b1;
        ex_mem_write_s  = 1'b1;
        mem_wb_write_s  = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_bubble_s  = 1'b0;
        ex_mem_bubble_s = 1'b0;
        mem_wb_bubble_s = 1'b0;
        fault_s         = 1'b0;
        flush_win_s     = 1'b0;
        if (in_fault_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
            mem_wb_write_s = 1'b0;
            fault_s        = 1'b1;
        end else if (mem_stall_s) begin
            pc_write_s      = 1'b0;
            if_id_write_s   = 1'b0;
            id_ex_write_s   = 1'b0;
            ex_mem_write_s  = 1'b0;
            mem_wb_bubble_s = 1'b1;
        end else if (mdu_hold_s) begin
            pc_write_s      = 1'b0;
            if_id_write_s   = 1'b0;
            id_ex_write_s   = 1'b0;
            ex_mem_bubble_s = 1'b1;
        end else if (bus.branch_taken_ex) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            flush_win_s    = 1'b1;
        end else if (load_use_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else begin
            flush_win_s = 1'b0;
        end
    end

    // Next state, timeout counter and saturating performance counters.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (timeout_s)
                    state_d = ST_FAULT;
                else if (bus.ex_mdu_start & ~bus.mdu_done & ~mem_stall_s)
                    state_d = ST_MDU_WAIT;
                else
                    state_d = ST_RUN;
            end
            ST_MDU_WAIT: begin
                if (timeout_s)
                    state_d = ST_FAULT;
                else if (bus.mdu_done & ~mem_stall_s)
                    state_d = ST_RUN;
                else
                    state_d = ST_MDU_WAIT;
            end
            ST_FAULT: begin
                if (bus.fault_clr)
                    state_d = ST_RUN;
                else
                    state_d = ST_FAULT;
            end
            default: state_d = ST_RUN;
        endcase

        if (in_fault_s || timeout_s)
            wait_cnt_d = '0;
        else if (mem_stall_s)
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        else
            wait_cnt_d = '0;

        if (~in_fault_s && ~pc_write_s && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        else
            stall_cnt_d = stall_cnt_q;

        if (flush_win_s && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        else
            flush_cnt_d = flush_cnt_q;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced inactive for as long as reset is held.
    assign bus.pc_write      = reset_n & pc_write_s;
    assign bus.if_id_write   = reset_n & if_id_write_s;
    assign bus.id_ex_write   = reset_n & id_ex_write_s;
    assign bus.ex_mem_write  = reset_n & ex_mem_write_s;
    assign bus.mem_wb_write  = reset_n & mem_wb_write_s;
    assign bus.if_id_flush   = reset_n & if_id_flush_s;
    assign bus.id_ex_bubble  = reset_n & id_ex_bubble_s;
    assign bus.ex_mem_bubble = reset_n & ex_mem_bubble_s;
    assign bus.mem_wb_bubble = reset_n & mem_wb_bubble_s;
    assign bus.fault         = reset_n & fault_s;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller with TIMEOUT=4, CNT_W=4.
module tb_pipeline_stall_controller;
    logic clk;
    logic reset_n;
    logic rst_v;

    pipeline_stall_controller_if #(.CNT_W(4)) sif ();

    pipeline_stall_controller #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl order: pc,if_id,id_ex,ex_mem,mem_wb writes, if_id_flush, id_ex/ex_mem/mem_wb bubbles, fault
    localparam logic [9:0] C_ZERO = 10'b0000000000;
    localparam logic [9:0] C_RUN  = 10'b1111100000;
    localparam logic [9:0] C_LU   = 10'b0011101000;
    localparam logic [9:0] C_BR   = 10'b1111111000;
    localparam logic [9:0] C_MDU  = 10'b0001100100;
    localparam logic [9:0] C_MEM  = 10'b0000100010;
    localparam logic [9:0] C_FLT  = 10'b0000000001;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_MW  = 2'b01;
    localparam logic [1:0] S_FLT = 2'b10;

    // flags: memread, branch, mdu_start, mdu_done, dmem_req, dmem_ready, fault_clr
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_LD   = 7'b1000000;
    localparam logic [6:0] F_BR   = 7'b0100000;
    localparam logic [6:0] F_MS   = 7'b0010000;
    localparam logic [6:0] F_MD   = 7'b0001000;
    localparam logic [6:0] F_DQ   = 7'b0000100;
    localparam logic [6:0] F_DR   = 7'b0000010;
    localparam logic [6:0] F_FC   = 7'b0000001;

    typedef struct {
        string      tag;
        logic [9:0] ctrl;
        logic [1:0] st;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [3:0] m_stall = 4'd0;
    logic [3:0] m_flush = 4'd0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [6:0] fl,
                        input logic [9:0] ctrl, input logic [1:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n             = rst_v;
        sif.rs1_id          = rs1;
        sif.rs2_id          = rs2;
        sif.id_ex_rd        = rd;
        sif.id_ex_memread   = fl[6];
        sif.branch_taken_ex = fl[5];
        sif.ex_mdu_start    = fl[4];
        sif.mdu_done        = fl[3];
        sif.dmem_req        = fl[2];
        sif.dmem_ready      = fl[1];
        sif.fault_clr       = fl[0];
        if (!rst_v) begin
            m_stall = 4'd0;
            m_flush = 4'd0;
        end
        e.tag  = tag;
        e.ctrl = ctrl;
        e.st   = st;
        e.sc   = m_stall;
        e.fc   = m_flush;
        sb.push_back(e);
        if (rst_v && !ctrl[0] && !ctrl[9] && (m_stall != 4'hF))
            m_stall = m_stall + 4'd1;
        if (rst_v && ctrl[4] && (m_flush != 4'hF))
            m_flush = m_flush + 4'd1;
    endtask

    // Compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk_eq({e.tag, ".ctrl"}, 32'({sif.pc_write, sif.if_id_write, sif.id_ex_write,
                   sif.ex_mem_write, sif.mem_wb_write, sif.if_id_flush, sif.id_ex_bubble,
                   sif.ex_mem_bubble, sif.mem_wb_bubble, sif.fault}), 32'(e.ctrl));
            chk_eq({e.tag, ".state"}, 32'(dut.state_q), 32'(e.st));
            chk_eq({e.tag, ".stall_cnt"}, 32'(sif.stall_cnt), 32'(e.sc));
            chk_eq({e.tag, ".flush_cnt"}, 32'(sif.flush_cnt), 32'(e.fc));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_v = 1'b0;
        reset_n = 1'b0;
        step("rst0", 5'd0, 5'd0, 5'd0, F_NONE, C_ZERO, S_RUN);
        step("rst1", 5'd0, 5'd0, 5'd0, F_NONE, C_ZERO, S_RUN);
        rst_v = 1'b1;
        step("idle",     5'd0, 5'd0, 5'd0, F_NONE, C_RUN, S_RUN);
        step("lu",       5'd5, 5'd0, 5'd5, F_LD,   C_LU,  S_RUN);
        step("lu_next",  5'd5, 5'd0, 5'd5, F_NONE, C_RUN, S_RUN);
        step("lu_x0",    5'd0, 5'd0, 5'd0, F_LD,   C_RUN, S_RUN);
        step("lu_rs2",   5'd1, 5'd7, 5'd7, F_LD,   C_LU,  S_RUN);
        step("lu_nomat", 5'd1, 5'd2, 5'd7, F_LD,   C_RUN, S_RUN);
        step("lu_br",    5'd5, 5'd0, 5'd5, F_LD | F_BR, C_BR, S_RUN);
        step("post_br",  5'd0, 5'd0, 5'd0, F_NONE, C_RUN, S_RUN);
        // four-cycle MDU op
        step("mdu1", 5'd0, 5'd0, 5'd0, F_MS,        C_MDU, S_RUN);
        step("mdu2", 5'd0, 5'd0, 5'd0, F_MS,        C_MDU, S_MW);
        step("mdu3", 5'd0, 5'd0, 5'd0, F_MS,        C_MDU, S_MW);
        step("mdu4", 5'd0, 5'd0, 5'd0, F_MS | F_MD, C_RUN, S_MW);
        step("mdu5", 5'd0, 5'd0, 5'd0, F_NONE,      C_RUN, S_RUN);
        step("mdu_1cyc",  5'd0, 5'd0, 5'd0, F_MS | F_MD, C_RUN, S_RUN);
        step("mdu_1next", 5'd0, 5'd0, 5'd0, F_NONE,      C_RUN, S_RUN);
        // memory stall arriving while the MDU is busy
        step("mm1", 5'd0, 5'd0, 5'd0, F_MS,                      C_MDU, S_RUN);
        step("mm2", 5'd0, 5'd0, 5'd0, F_MS | F_DQ,               C_MEM, S_MW);
        step("mm3", 5'd0, 5'd0, 5'd0, F_MS | F_MD | F_DQ,        C_MEM, S_MW);
        step("mm4", 5'd0, 5'd0, 5'd0, F_MS | F_MD | F_DQ,        C_MEM, S_MW);
        step("mm5", 5'd0, 5'd0, 5'd0, F_MS | F_MD | F_DQ | F_DR, C_RUN, S_MW);
        step("mm6", 5'd0, 5'd0, 5'd0, F_NONE,                    C_RUN, S_RUN);
        step("br",      5'd0, 5'd0, 5'd0, F_BR,        C_BR,  S_RUN);
        step("br_mdu",  5'd0, 5'd0, 5'd0, F_BR | F_MS, C_MDU, S_RUN);
        step("br_mdu2", 5'd0, 5'd0, 5'd0, F_MS | F_MD, C_RUN, S_MW);
        step("mem_lu",  5'd5, 5'd0, 5'd5, F_LD | F_DQ, C_MEM, S_RUN);
        step("mem_rdy", 5'd0, 5'd0, 5'd0, F_DQ | F_DR, C_RUN, S_RUN);
        // timeout into FAULT, recovery, and stall counter saturation
        step("to1",  5'd0, 5'd0, 5'd0, F_DQ,        C_MEM, S_RUN);
        step("to2",  5'd0, 5'd0, 5'd0, F_DQ,        C_MEM, S_RUN);
        step("to3",  5'd0, 5'd0, 5'd0, F_DQ,        C_MEM, S_RUN);
        step("to4",  5'd0, 5'd0, 5'd0, F_DQ,        C_MEM, S_RUN);
        step("flt1", 5'd0, 5'd0, 5'd0, F_DQ,        C_FLT, S_FLT);
        step("flt2", 5'd0, 5'd0, 5'd0, F_DQ | F_BR, C_FLT, S_FLT);
        step("fclr", 5'd0, 5'd0, 5'd0, F_DQ | F_FC, C_FLT, S_FLT);
        step("rs1",  5'd0, 5'd0, 5'd0, F_DQ,        C_MEM, S_RUN);
        step("rs2",  5'd0, 5'd0, 5'd0, F_DQ,        C_MEM, S_RUN);
        step("rs3",  5'd0, 5'd0, 5'd0, F_DQ,        C_MEM, S_RUN);
        step("rs_end", 5'd0, 5'd0, 5'd0, F_NONE,    C_RUN, S_RUN);
        for (int i = 0; i < 6; i++)
            step("sat_lu", 5'd3, 5'd0, 5'd3, F_LD, C_LU, S_RUN);
        // reset while waiting on the MDU
        step("pr1",   5'd0, 5'd0, 5'd0, F_MS, C_MDU, S_RUN);
        step("pr2",   5'd0, 5'd0, 5'd0, F_MS, C_MDU, S_MW);
        rst_v = 1'b0;
        step("mrst1", 5'd0, 5'd0, 5'd0, F_MS, C_ZERO, S_RUN);
        step("mrst2", 5'd3, 5'd0, 5'd3, F_LD | F_MS, C_ZERO, S_RUN);
        rst_v = 1'b1;
        step("post_rst", 5'd0, 5'd0, 5'd0, F_NONE, C_RUN, S_RUN);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It replaces the stand-alone load-use detector. It merges four hazard sources into one prioritised set of per-stage write-enable and bubble controls:
- data-memory wait states
- a multi-cycle mul/div unit (MDU)
- taken branches resolved in EX
- load-use hazards

It also tracks MDU occupancy, detects data-memory timeouts, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT, 255, number of consecutive memory-stall cycles tolerated before fault (≥2)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- rs1_id, rs2_id  in  5  source registers of the instruction in ID
- id_ex_rd  in  5  destination register in ID/EX
- id_ex_memread  in  1  ID/EX instruction is a load
- branch_taken_ex  in  1  branch/jump in EX is taken (redirect this cycle)
- ex_mdu_start  in  1  ID/EX holds an MDU op (valid while it sits in EX)
- mdu_done  in  1  MDU result valid this cycle
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- fault_clr  in  1  leave FAULT
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  stage register enables
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1  load NOP into that register (when its write=1)
- fault  out  1  memory timeout occurred
- stall_cnt  out  CNT_W  cycles with pc_write=0 (excluding FAULT)
- flush_cnt  out  CNT_W  branch flushes taken

## Operation
- States:
  - RUN
  - MDU_WAIT
  - FAULT
- Internal wait_cnt holds ceil(log2(TIMEOUT+1)) bits.
- Internal signals:
  - mem_stall = dmem_req & ~dmem_ready
  - mdu_hold = ex_mdu_start & ~mdu_done, in RUN or MDU_WAIT
  - load_use = id_ex_memread & (id_ex_rd≠0) & (id_ex_rd==rs1_id | id_ex_rd==rs2_id)
- Outputs are combinational from the state and inputs. Rules apply in priority order; the first match wins.
- Defaults: all writes=1, all bubbles/flush=0.
  1. State FAULT: all writes=0; fault=1.
  2. mem_stall: pc, if_id, id_ex, ex_mem writes=0; mem_wb_write=1 with mem_wb_bubble=1.
  3. mdu_hold: pc, if_id, id_ex writes=0; ex_mem_bubble=1.
  4. branch_taken_ex: pc_write=1, if_id_flush=1, id_ex_bubble=1. This overrides load_use.
  5. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1.
- Transitions:
  - RUN→MDU_WAIT when ex_mdu_start & ~mdu_done & ~mem_stall.
  - MDU_WAIT→RUN when mdu_done & ~mem_stall.
  - RUN or MDU_WAIT→FAULT when mem_stall & wait_cnt==TIMEOUT−1.
  - FAULT→RUN when fault_clr.
- wait_cnt:
  - +1 on each mem_stall cycle outside FAULT.
  - Cleared when ~mem_stall.
  - Cleared on entering FAULT and during FAULT.
- Counters saturate at all-ones:
  - stall_cnt +1 each non-FAULT cycle with pc_write=0.
  - flush_cnt +1 each cycle where rule 4 is the winning rule.
- fault is asserted only while in FAULT.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - State = RUN.
  - wait_cnt, stall_cnt, flush_cnt = 0; fault = 0.
  - All write enables, bubbles and flush are forced to 0.
- Releasing reset_n yields the RUN defaults on the next evaluation. No registered output lag.
- Load-use hazard costs exactly 1 stall cycle. The next cycle ID/EX holds the bubble, so load_use deasserts.
- MDU op of N cycles (mdu_done in the N-th cycle of ex_mdu_start) stalls N−1 cycles. mdu_done in the first cycle gives zero stall and no MDU_WAIT entry.
- Branch flush costs 2 slots (IF/ID, ID/EX) with no stall cycle.
- mem_stall arriving in MDU_WAIT freezes everything. The state stays MDU_WAIT even if mdu_done is present; the MDU must hold mdu_done until the freeze ends.
- The FAULT transition happens on the clock edge where the TIMEOUT-th consecutive stall cycle ends. fault is high from the following cycle.
- fault_clr together with mem_stall: the state goes to RUN and wait_cnt restarts from 0.
- reset_n asserted mid-MDU_WAIT or mid-FAULT returns the state to RUN immediately.

## Test plan
- Load x5; next instr uses rs1=x5 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1. Same sequence with rd=x0 → no stall.
- Load-use plus branch_taken_ex in the same cycle → pc_write=1, if_id_flush=1, id_ex_bubble=1; flush_cnt=1; stall_cnt unchanged.
- ex_mdu_start held, mdu_done on the 4th cycle → 3 stall cycles with ex_mem_bubble=1; state MDU_WAIT for cycles 2–4; back to RUN after the done cycle.
- dmem_req=1, dmem_ready=0 for 3 cycles mid-MDU → all of pc/if_id/id_ex/ex_mem writes=0 and mem_wb_bubble=1 for 3 cycles; MDU completion is deferred until after.
- TIMEOUT=4, dmem_ready stuck 0 → fault=1 from cycle 5; all writes=0. Pulse fault_clr → RUN, fault=0.
- Force stall_cnt near saturation (CNT_W=4, 20 stall cycles) → holds at 15. Assert reset_n=0 mid-MDU_WAIT → state RUN, counters 0, all enables 0 while low.
